// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit-PC / 16-bit-instruction CPU control path.
// Holds the sequencer state encoding, the 4-bit opcode map, the one-hot ALU
// operation codes and the sticky error codes reported by the controller.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    NEXT,
    HALT,
    ERR
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [7:0] ALU_ADD = 8'h01;
  localparam logic [7:0] ALU_SUB = 8'h02;
  localparam logic [7:0] ALU_AND = 8'h04;
  localparam logic [7:0] ALU_OR  = 8'h08;
  localparam logic [7:0] ALU_XOR = 8'h10;
  localparam logic [7:0] ALU_SLT = 8'h20;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode decoder, shared by the single-cycle and multi-cycle
// control units so both use one encoding table.
//   opcode     in  4  instruction bits [15:12]
//   alu_op     out 8  one-hot ALU operation, 0 for non-ALU opcodes
//   is_nop     out 1  opcode is NOP
//   is_halt    out 1  opcode is HALT
//   is_illegal out 1  opcode is not in the instruction set
module op_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [7:0] alu_op,
  output logic       is_nop,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    alu_op     = '0;
    is_nop     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_NOP:  is_nop  = 1'b1;
      OP_ADD:  alu_op  = ALU_ADD;
      OP_SUB:  alu_op  = ALU_SUB;
      OP_AND:  alu_op  = ALU_AND;
      OP_OR:   alu_op  = ALU_OR;
      OP_XOR:  alu_op  = ALU_XOR;
      OP_SLT:  alu_op  = ALU_SLT;
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: FETCH -> DECODE -> EXEC -> WB -> NEXT.
// Latches the instruction, drives register addresses and ALU op, gates one
// register write and one PC increment per instruction, and stops on HALT,
// illegal opcode or fetch timeout.
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   start      in   level; run request (leave IDLE / continue after NEXT)
//   imem_ack   in   instruction word valid
//   imem_rdata in   16-bit instruction word
//   imem_req   out  fetch request, high throughout FETCH
//   pc_en      out  PC increment strobe (NEXT)
//   rd_reg1/rd_reg2/wr_reg out  register addresses ir[8:6], ir[5:3], ir[2:0]
//   alu_op     out  one-hot ALU operation, nonzero only in EXEC and WB
//   wr_en      out  register-file write strobe (WB)
//   busy       out  high except in IDLE, HALT and ERR
//   halted     out  high in HALT
//   err        out  sticky error code
//   retired    out  saturating count of completed instructions
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES   = 1,
  parameter int unsigned FETCH_TIMEOUT = 15,
  parameter int unsigned RETIRE_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                imem_ack,
  input  logic [15:0]         imem_rdata,
  output logic                imem_req,
  output logic                pc_en,
  output logic [2:0]          rd_reg1,
  output logic [2:0]          rd_reg2,
  output logic [2:0]          wr_reg,
  output logic [7:0]          alu_op,
  output logic                wr_en,
  output logic                busy,
  output logic                halted,
  output logic [1:0]          err,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [7:0]          TMO_LAST    = 8'(FETCH_TIMEOUT - 1);
  localparam logic [3:0]          SETTLE_LAST = 4'(EXEC_CYCLES - 1);
  localparam logic [RETIRE_W-1:0] RET_ONE     = RETIRE_W'(1);

  state_t      state_q, state_d;
  logic [15:0] ir_q;
  logic [7:0]  tmo_q;
  logic [3:0]  settle_q;

  logic [7:0]  dec_alu_op;
  logic        dec_nop, dec_halt, dec_illegal;

  // ir[11:9] carry no meaning for this instruction set.
  logic        unused_ir_bits;
  assign unused_ir_bits = ^ir_q[11:9];

  op_decode u_op_decode (
    .opcode     (ir_q[15:12]),
    .alu_op     (dec_alu_op),
    .is_nop     (dec_nop),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

  assign rd_reg1 = ir_q[8:6];
  assign rd_reg2 = ir_q[5:3];
  assign wr_reg  = ir_q[2:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      // ack on the last allowed cycle still wins over the timeout
      FETCH:   if (imem_ack)              state_d = DECODE;
               else if (tmo_q == TMO_LAST) state_d = ERR;
      DECODE:  if (dec_halt)         state_d = HALT;
               else if (dec_illegal) state_d = ERR;
               else if (dec_nop)     state_d = NEXT;
               else                  state_d = EXEC;
      EXEC:    if (settle_q == SETTLE_LAST) state_d = WB;
      WB:      state_d = NEXT;
      NEXT:    state_d = start ? FETCH : IDLE;
      HALT:    state_d = HALT;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up exactly
  // with the state they belong to, and clear asynchronously with reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ir_q     <= '0;
      tmo_q    <= '0;
      settle_q <= '0;
      imem_req <= 1'b0;
      pc_en    <= 1'b0;
      alu_op   <= '0;
      wr_en    <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      err      <= ERR_NONE;
      retired  <= '0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= (state_q == FETCH && state_d == FETCH) ? tmo_q + 8'd1 : '0;
      settle_q <= (state_q == EXEC && state_d == EXEC) ? settle_q + 4'd1 : '0;
      if (state_q == FETCH && imem_ack)
        ir_q <= imem_rdata;

      imem_req <= (state_d == FETCH);
      pc_en    <= (state_d == NEXT);
      wr_en    <= (state_d == WB);
      busy     <= !(state_d inside {IDLE, HALT, ERR});
      halted   <= (state_d == HALT);
      alu_op   <= (state_d == EXEC || state_d == WB) ? dec_alu_op : '0;

      if (state_q == FETCH && state_d == ERR)
        err <= ERR_TIMEOUT;
      else if (state_q == DECODE && state_d == ERR)
        err <= ERR_ILLEGAL;

      if (state_d == NEXT && retired != '1)
        retired <= retired + RET_ONE;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instance A uses default
// parameters, instance B uses EXEC_CYCLES=4 and a 4-bit retire counter.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst = 1'b1, a_start = 1'b0, a_ack = 1'b0;
  logic [15:0] a_rdata = '0;
  logic        a_req, a_pc_en, a_wr_en, a_busy, a_halted;
  logic [2:0]  a_rd1, a_rd2, a_wr;
  logic [7:0]  a_alu;
  logic [1:0]  a_err;
  logic [15:0] a_retired;

  logic        b_rst = 1'b1, b_start = 1'b0, b_ack = 1'b0;
  logic [15:0] b_rdata = '0;
  logic        b_req, b_pc_en, b_wr_en, b_busy, b_halted;
  logic [2:0]  b_rd1, b_rd2, b_wr;
  logic [7:0]  b_alu;
  logic [1:0]  b_err;
  logic [3:0]  b_retired;

  multicycle_ctrl #(.EXEC_CYCLES(1), .FETCH_TIMEOUT(15), .RETIRE_W(16)) u_dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .imem_ack(a_ack), .imem_rdata(a_rdata),
    .imem_req(a_req), .pc_en(a_pc_en), .rd_reg1(a_rd1), .rd_reg2(a_rd2), .wr_reg(a_wr),
    .alu_op(a_alu), .wr_en(a_wr_en), .busy(a_busy), .halted(a_halted), .err(a_err),
    .retired(a_retired)
  );

  multicycle_ctrl #(.EXEC_CYCLES(4), .FETCH_TIMEOUT(15), .RETIRE_W(4)) u_dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .imem_ack(b_ack), .imem_rdata(b_rdata),
    .imem_req(b_req), .pc_en(b_pc_en), .rd_reg1(b_rd1), .rd_reg2(b_rd2), .wr_reg(b_wr),
    .alu_op(b_alu), .wr_en(b_wr_en), .busy(b_busy), .halted(b_halted), .err(b_err),
    .retired(b_retired)
  );

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] model_alu(input logic [3:0] op);
    case (op)
      4'h1: return 8'h01;
      4'h2: return 8'h02;
      4'h3: return 8'h04;
      4'h4: return 8'h08;
      4'h5: return 8'h10;
      4'h6: return 8'h20;
      default: return 8'h00;
    endcase
  endfunction

  // Scoreboard for instance A: one entry per instruction expected to retire.
  typedef struct packed {
    logic [7:0]  alu;
    logic [2:0]  wr;
    logic        writes;
    logic [15:0] ret;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        sb_e;
  logic        a_wseen = 1'b0;
  int unsigned a_pc_cnt = 0, a_wr_cnt = 0, a_issued = 0;

  always @(negedge clk) begin
    if (!a_rst) begin
      a_wseen = 1'b0;
    end else begin
      if (a_wr_en) begin
        a_wr_cnt++;
        check("wr_pc_overlap", a_pc_en, 0);
        if (sb_q.size() == 0) check("wr_unexpected", a_wr_en, 0);
        else begin
          check("wb_alu_op", a_alu, sb_q[0].alu);
          check("wb_wr_reg", a_wr, sb_q[0].wr);
          a_wseen = 1'b1;
        end
      end
      if (a_pc_en) begin
        a_pc_cnt++;
        if (sb_q.size() == 0) check("pc_unexpected", a_pc_en, 0);
        else begin
          sb_e = sb_q.pop_front();
          check("retire_wrote", a_wseen, sb_e.writes);
          check("retire_count", a_retired, sb_e.ret);
          a_wseen = 1'b0;
        end
      end
    end
  end

  // Saturating retire model for instance B.
  int unsigned b_exp = 0, b_pc_cnt = 0;
  always @(negedge clk) begin
    if (!b_rst) begin
      b_exp = 0;
      b_pc_cnt = 0;
    end else if (b_pc_en) begin
      b_pc_cnt++;
      b_exp = (b_exp == 15) ? 15 : b_exp + 1;
      check("b_retired", b_retired, b_exp);
      check("b_wr_pc_overlap", b_wr_en, 0);
    end
  end

  task automatic serve(input bit sel, input logic [15:0] instr, input int unsigned wait_cyc);
    int unsigned n = 0;
    while (!(sel ? b_req : a_req) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(sel ? b_req : a_req)) begin
      check("fetch_req_seen", sel ? b_req : a_req, 1);
      return;
    end
    repeat (wait_cyc) @(negedge clk);
    if (!sel) begin
      a_ack = 1'b1;
      a_rdata = instr;
      if (instr[15:12] <= 4'h6) begin
        a_issued++;
        sb_q.push_back('{alu: model_alu(instr[15:12]), wr: instr[2:0],
                         writes: (instr[15:12] != 4'h0), ret: 16'(a_issued)});
      end
    end else begin
      b_ack = 1'b1;
      b_rdata = instr;
    end
    @(negedge clk);
    a_ack = 1'b0;
    b_ack = 1'b0;
  endtask

  task automatic reset_a();
    @(negedge clk);
    #1 a_rst = 1'b0;
    a_start = 1'b0;
    a_ack = 1'b0;
    sb_q.delete();
    a_issued = 0;
    a_pc_cnt = 0;
    a_wr_cnt = 0;
    @(negedge clk);
    #1 a_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic reset_b();
    @(negedge clk);
    #1 b_rst = 1'b0;
    b_start = 1'b0;
    b_ack = 1'b0;
    @(negedge clk);
    #1 b_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain_a();
    int unsigned n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    logic [15:0] w;
    logic [3:0]  op;
    int unsigned n;

    #2 a_rst = 1'b0;
    b_rst = 1'b0;
    #3;
    check("rst_a_outs", {a_req, a_pc_en, a_wr_en, a_busy, a_halted, a_err, a_alu,
                         a_rd1, a_rd2, a_wr}, 0);
    check("rst_a_retired", a_retired, 0);
    check("rst_b_outs", {b_req, b_pc_en, b_wr_en, b_busy, b_halted, b_err, b_alu,
                         b_retired}, 0);
    @(negedge clk);
    #1 a_rst = 1'b1;
    b_rst = 1'b1;
    @(negedge clk);

    // ADD, cycle by cycle: FETCH(ack) DECODE EXEC WB NEXT
    a_start = 1'b1;
    serve(0, 16'h1053, 0);
    a_start = 1'b0;
    check("add_rd_reg1", a_rd1, 1);
    check("add_rd_reg2", a_rd2, 2);
    check("add_wr_reg", a_wr, 3);
    check("add_decode_alu", a_alu, 0);
    check("add_decode_busy", a_busy, 1);
    @(negedge clk);
    check("add_exec_alu", a_alu, 8'h01);
    check("add_exec_wr_en", a_wr_en, 0);
    @(negedge clk);
    check("add_wb_wr_en", a_wr_en, 1);
    check("add_wb_alu", a_alu, 8'h01);
    @(negedge clk);
    check("add_next_pc_en", a_pc_en, 1);
    check("add_next_retired", a_retired, 1);
    check("add_next_alu", a_alu, 0);
    @(negedge clk);
    check("add_idle_pc_en", a_pc_en, 0);
    check("add_idle_busy", a_busy, 0);

    // Back-to-back ALU ops with random register fields and ack delays
    reset_a();
    a_start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = 4'(1 + (i % 6));
      w = {op, 12'($urandom)};
      serve(0, w, int'(i % 3));
    end
    a_start = 1'b0;
    drain_a();
    check("seq_wr_count", a_wr_cnt, 8);
    check("seq_pc_count", a_pc_cnt, 8);

    // NOP then HALT
    reset_a();
    a_start = 1'b1;
    serve(0, 16'h0000, 0);
    serve(0, 16'hF000, 0);
    a_start = 1'b0;
    repeat (4) @(negedge clk);
    check("halt_halted", a_halted, 1);
    check("halt_busy", a_busy, 0);
    check("halt_retired", a_retired, 1);
    check("halt_pc_count", a_pc_cnt, 1);
    check("halt_wr_count", a_wr_cnt, 0);
    repeat (4) begin
      a_start = ~a_start;
      @(negedge clk);
    end
    check("halt_sticky", a_halted, 1);
    check("halt_no_req", a_req, 0);

    // Illegal opcode
    reset_a();
    a_start = 1'b1;
    serve(0, 16'h7000, 0);
    @(negedge clk);
    check("ill_err", a_err, 1);
    check("ill_busy", a_busy, 0);
    repeat (6) begin
      a_start = ~a_start;
      @(negedge clk);
    end
    check("ill_err_sticky", a_err, 1);
    check("ill_no_req", a_req, 0);
    check("ill_no_strobes", a_pc_cnt + a_wr_cnt, 0);
    check("ill_not_halted", a_halted, 0);

    // Fetch timeout with no ack
    reset_a();
    a_start = 1'b1;
    n = 0;
    while (!a_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (a_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("tmo_fetch_cycles", n, 15);
    check("tmo_err", a_err, 2);
    check("tmo_busy", a_busy, 0);

    // Ack on exactly the 15th FETCH cycle is accepted
    reset_a();
    a_start = 1'b1;
    serve(0, 16'h2ABC, 14);
    a_start = 1'b0;
    drain_a();
    check("tmo_edge_err", a_err, 0);
    check("tmo_edge_retired", a_retired, 1);

    // Reset in the 2nd EXEC cycle of a 4-cycle EXEC
    reset_b();
    b_start = 1'b1;
    serve(1, 16'h1053, 0);
    b_start = 1'b0;
    @(negedge clk);
    check("b_exec1_alu", b_alu, 8'h01);
    @(negedge clk);
    check("b_exec2_alu", b_alu, 8'h01);
    #1 b_rst = 1'b0;
    #1;
    check("b_midrst_outs", {b_req, b_pc_en, b_wr_en, b_busy, b_halted, b_err, b_alu,
                            b_retired}, 0);
    @(negedge clk);
    #1 b_rst = 1'b1;
    b_start = 1'b1;
    serve(1, 16'h3111, 0);
    b_start = 1'b0;
    n = 0;
    while (!b_pc_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b_after_rst_pc_en", b_pc_en, 1);
    check("b_after_rst_retired", b_retired, 1);

    // Retire counter saturation over 20 NOPs
    reset_b();
    b_start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      serve(1, 16'h0000, 0);
      if (i == 19) b_start = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("sat_retired", b_retired, 4'hF);
    check("sat_pc_count", b_pc_cnt, 20);
    check("sat_idle_busy", b_busy, 0);
    check("sat_idle_req", b_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control sequencer for the 8-bit-PC / 16-bit-instruction CPU datapath. It steps PC, instruction memory, register file and ALU through FETCH -> DECODE -> EXEC -> WB -> NEXT instead of a single-cycle combinational decode. It latches the instruction, drives register addresses and ALU op, gates register writes to one cycle per instruction, and handles halt, illegal opcode and fetch timeout.

Parameters:
EXEC_CYCLES, 1, ALU settle cycles spent in EXEC (1..15).
FETCH_TIMEOUT, 15, max cycles waiting for imem_ack before the error stop (1..255).
RETIRE_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  level; leaves IDLE when high
imem_ack  in  1  instruction-memory data valid, sampled in FETCH
imem_rdata  in  16  instruction word, valid when imem_ack=1
imem_req  out  1  fetch request, high throughout FETCH
pc_en  out  1  one-cycle PC increment strobe
rd_reg1  out  3  ir[8:6]
rd_reg2  out  3  ir[5:3]
wr_reg  out  3  ir[2:0]
alu_op  out  8  one-hot ALU operation
wr_en  out  1  register-file write strobe
busy  out  1  high in every state except IDLE, HALT and ERR
halted  out  1  sticky; high in HALT
err  out  2  sticky error code: 0 none, 1 illegal opcode, 2 fetch timeout
retired  out  RETIRE_W  count of completed instructions, saturating

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; ir = 0; all counters = 0.
  - All outputs = 0, including alu_op = 8'h00.
- The opcode is ir[15:12]; ir[11:9] are ignored.
  - 0x0 NOP
  - 0x1 ADD -> alu_op 8'h01
  - 0x2 SUB -> 8'h02
  - 0x3 AND -> 8'h04
  - 0x4 OR -> 8'h08
  - 0x5 XOR -> 8'h10
  - 0x6 SLT -> 8'h20
  - 0xF HALT
  - All other opcodes are illegal.
- IDLE: if start=1, go to FETCH on the next edge.
- FETCH:
  - imem_req=1; the timeout counter increments each cycle.
  - imem_ack=1: latch imem_rdata into ir and go to DECODE. Ack in the same cycle as the counter reaching FETCH_TIMEOUT wins over the timeout.
  - Counter reaches FETCH_TIMEOUT with no ack: err=2, go to ERR.
- DECODE (1 cycle):
  - HALT -> HALT state.
  - Illegal -> err=1, go to ERR.
  - NOP -> NEXT.
  - Otherwise -> EXEC.
- EXEC:
  - alu_op is driven from ir; the settle counter runs EXEC_CYCLES cycles, then goes to WB.
  - alu_op is nonzero only in EXEC and WB.
- WB (1 cycle): wr_en=1, alu_op still held; go to NEXT.
- NEXT (1 cycle):
  - pc_en=1; retired += 1, saturating at all-ones.
  - If start=1, go to FETCH; else go to IDLE.
- HALT: halted=1; pc_en is not asserted. Leave only via reset.
- ERR: err held; no strobes. Leave only via reset.
- Register addresses: rd_reg1, rd_reg2 and wr_reg are continuous slices of ir, stable from DECODE through NEXT.
- Strobes: wr_en and pc_en are never high in the same cycle. Each fires at most once per instruction.
- Reset mid-instruction forces IDLE immediately. A pending fetch is abandoned: imem_req falls asynchronously.
- Latency: instruction-issue to retire = ack cycle + DECODE + EXEC_CYCLES + WB + NEXT. With EXEC_CYCLES=1 and ack in the first FETCH cycle, that is 5 cycles.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum: IDLE, FETCH, DECODE, EXEC, WB, NEXT, HALT, ERR
  - opcode constants (OP_NOP..OP_HALT)
  - one-hot ALU op constants (ALU_ADD..ALU_SLT)
  - error codes (ERR_NONE, ERR_ILLEGAL, ERR_TIMEOUT)
- One sub-module, op_decode: combinational opcode -> {alu_op, is_nop, is_halt, is_illegal}. It is shared with the existing single-cycle CU so both use one encoding table.

Test Plan:
- ADD sequence: start=1, ack in first FETCH cycle with imem_rdata=16'h1053.
  - FETCH..NEXT takes 5 cycles.
  - rd_reg1=1, rd_reg2=2, wr_reg=3.
  - alu_op=8'h01 in EXEC/WB; wr_en pulses in WB only; pc_en pulses the following cycle; retired=1.
- NOP then HALT: fetch 16'h0000 then 16'hF000.
  - No wr_en.
  - One pc_en (after the NOP) before the HALT instruction; HALT itself pulses no pc_en.
  - halted=1 and busy=0; retired stays 1.
- Illegal opcode 16'h7000: err=1 after DECODE, busy=0, no wr_en or pc_en ever; stays in ERR while start toggles.
- Fetch timeout: imem_ack held 0 with FETCH_TIMEOUT=15 -> err=2 after 15 FETCH cycles, imem_req drops.
  - Repeat with ack on exactly cycle 15: instruction is accepted and err=0.
- Reset mid-EXEC with EXEC_CYCLES=4: assert rst=0 in the 2nd EXEC cycle.
  - All outputs 0 immediately.
  - After release with start=1, the next fetch proceeds and retired counts from 0.
- Saturation: with RETIRE_W=4, run 20 NOPs -> retired stops at 4'hF; start=0 after a NEXT returns to IDLE.
